// File: rtl/update_pkg.sv
// Shared types and default widths for the delayed read-modify-write responder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package update_pkg;

    localparam int DW_DEF = 4;
    localparam int CW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SET = 1'b1
    } op_t;

endpackage

// File: rtl/update_delay_cnt.sv
// Loadable down-counter whose terminal-count flag marks the last wait cycle.
// Latency: load visible one edge after i_load; o_tc is combinational on the count.
// Backpressure: none; decrements only while i_dec is high and the count is nonzero.
module update_delay_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    // Load takes priority; otherwise count down, saturating at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A count of one means this is the final wait cycle.
    assign o_tc = (r_cnt == CW'(1));

endmodule

// File: rtl/delayed_update_responder.sv
// Delayed read-modify-write responder: accepts op/delta/delay, waits, updates val; optional UPDATE_OVF_EN adds sticky ovf.
// Latency: new val, done and val_changed appear delay + 1 edges after the accepting edge.
// Backpressure: req_ready low while busy or while init_load is high; initiator holds the request.
module delayed_update_responder
    import update_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_op,
    input  logic [DW-1:0] req_delta,
    input  logic [CW-1:0] req_delay,
    input  logic          init_load,
    input  logic [DW-1:0] init_value,
    output logic [DW-1:0] val,
`ifdef UPDATE_OVF_EN
    output logic          ovf,
`endif
    output logic          val_changed,
    output logic          done,
    output logic          busy
);

    state_t        r_state;
    op_t           r_op;
    logic [DW-1:0] r_delta;
    logic [DW-1:0] r_val;
    logic          r_done;
    logic          r_val_changed;

    logic          w_accept;
    logic          w_cnt_load;
    logic          w_cnt_dec;
    logic          w_cnt_tc;
    logic [DW-1:0] w_new_val;
`ifdef UPDATE_OVF_EN
    logic [DW:0]   w_sum;
    logic          w_carry;
    logic          r_ovf;
`else
    logic [DW-1:0] w_sum;
`endif

    // init_load blocks the request path so the direct load always wins in IDLE.
    assign req_ready = (r_state == IDLE) && !init_load;
    assign w_accept  = req_valid && req_ready;
    assign busy      = (r_state != IDLE);

    // Only non-zero delays go through the counter; zero goes straight to APPLY.
    assign w_cnt_load = w_accept && (req_delay != '0);
    assign w_cnt_dec  = (r_state == WAIT);

    update_delay_cnt #(
        .CW (CW)
    ) u_delay_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (req_delay),
        .i_dec      (w_cnt_dec),
        .o_tc       (w_cnt_tc)
    );

    // Result of the latched operation; add wraps modulo 2^DW.
    always_comb begin
        w_sum = '0;
`ifdef UPDATE_OVF_EN
        w_sum     = {1'b0, r_val} + {1'b0, r_delta};
        w_carry   = w_sum[DW];
        w_new_val = (r_op == OP_SET) ? r_delta : w_sum[DW-1:0];
`else
        w_sum     = r_val + r_delta;
        w_new_val = (r_op == OP_SET) ? r_delta : w_sum;
`endif
    end

    // Control FSM with the value register and registered done/val_changed pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_op          <= OP_ADD;
            r_delta       <= '0;
            r_val         <= '0;
            r_done        <= 1'b0;
            r_val_changed <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_val_changed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_load) begin
                        r_val         <= init_value;
                        r_val_changed <= (init_value != r_val);
                    end else if (req_valid) begin
                        r_op    <= op_t'(req_op);
                        r_delta <= req_delta;
                        r_state <= (req_delay == '0) ? APPLY : WAIT;
                    end
                end
                WAIT: begin
                    if (w_cnt_tc) begin
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    r_val         <= w_new_val;
                    r_done        <= 1'b1;
                    r_val_changed <= (w_new_val != r_val);
                    r_state       <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef UPDATE_OVF_EN
    // Sticky carry-out flag: set by a carrying add, cleared by a direct load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == IDLE) && init_load) begin
            r_ovf <= 1'b0;
        end else if ((r_state == APPLY) && (r_op == OP_ADD) && w_carry) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

    assign val         = r_val;
    assign done        = r_done;
    assign val_changed = r_val_changed;

endmodule

// File: tb/tb_delayed_update_responder.sv
// Directed bench for delayed_update_responder with hand-computed expectations.
// Latency: drives and samples 1 time unit after each rising edge.
// Backpressure: requests are held until the accepting edge, as an initiator would.
module tb_delayed_update_responder;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [3:0] req_delta;
    logic [2:0] req_delay;
    logic       init_load;
    logic [3:0] init_value;
    logic [3:0] val;
    logic       val_changed;
    logic       done;
    logic       busy;
`ifdef UPDATE_OVF_EN
    logic       ovf;
`endif

    int n_chk;
    int n_pass;
    int n_pulses;

    delayed_update_responder #(
        .DW (4),
        .CW (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_delta   (req_delta),
        .req_delay   (req_delay),
        .init_load   (init_load),
        .init_value  (init_value),
        .val         (val),
`ifdef UPDATE_OVF_EN
        .ovf         (ovf),
`endif
        .val_changed (val_changed),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(input logic op, input logic [3:0] delta, input logic [2:0] delay);
        req_valid = 1'b1;
        req_op    = op;
        req_delta = delta;
        req_delay = delay;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_delta  = '0;
        req_delay  = '0;
        init_load  = 1'b0;
        init_value = '0;

        // Reset state
        tick();
        tick();
        chk("rst_val", val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vchg", val_changed, 0);
        chk("rst_ready", req_ready, 1);
`ifdef UPDATE_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        tick();

        // init_load 5
        init_load  = 1'b1;
        init_value = 4'd5;
        #1;
        chk("init_ready_low", req_ready, 0);
        tick();
        init_load = 1'b0;
        chk("init_val", val, 5);
        chk("init_vchg", val_changed, 1);
        chk("init_done", done, 0);
        tick();
        chk("init_vchg_off", val_changed, 0);

        // add 3, delay 2: update at acceptance + 3 edges
        put_req(1'b0, 4'd3, 3'd2);
        tick();
        req_valid = 1'b0;
        chk("d2_busy_e0", busy, 1);
        tick();
        chk("d2_busy_e1", busy, 1);
        tick();
        chk("d2_busy_e2", busy, 1);
        chk("d2_val_hold", val, 5);
        chk("d2_done_early", done, 0);
        tick();
        chk("d2_val", val, 8);
        chk("d2_done", done, 1);
        chk("d2_vchg", val_changed, 1);
        chk("d2_busy_off", busy, 0);
        chk("d2_ready", req_ready, 1);
        tick();
        chk("d2_done_off", done, 0);

        // add 5 delay 0, then held back-to-back add 5 wraps to 2
        put_req(1'b0, 4'd5, 3'd0);
        tick();
        chk("d0_busy", busy, 1);
        chk("d0_val_hold", val, 8);
        tick();
        chk("d0_val", val, 13);
        chk("d0_done", done, 1);
        chk("d0_ready_in_done", req_ready, 1);
`ifdef UPDATE_OVF_EN
        chk("d0_ovf_clear", ovf, 0);
`endif
        tick();
        req_valid = 1'b0;
        chk("b2b_busy", busy, 1);
        tick();
        chk("wrap_val", val, 2);
        chk("wrap_done", done, 1);
        chk("wrap_vchg", val_changed, 1);
`ifdef UPDATE_OVF_EN
        chk("wrap_ovf", ovf, 1);
`endif

        // add 0 then set to current value: done without val_changed
        put_req(1'b0, 4'd0, 3'd0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("add0_done", done, 1);
        chk("add0_vchg", val_changed, 0);
        chk("add0_val", val, 2);
        put_req(1'b1, 4'd2, 3'd1);
        tick();
        req_valid = 1'b0;
        tick();
        chk("set_same_wait", done, 0);
        tick();
        chk("set_same_done", done, 1);
        chk("set_same_vchg", val_changed, 0);
        chk("set_same_val", val, 2);
`ifdef UPDATE_OVF_EN
        chk("set_ovf_kept", ovf, 1);
`endif

        // init_load and req_valid together: load wins, request taken next cycle
        init_load  = 1'b1;
        init_value = 4'd9;
        put_req(1'b1, 4'd4, 3'd0);
        #1;
        chk("clash_ready", req_ready, 0);
        tick();
        init_load = 1'b0;
        chk("clash_val", val, 9);
        chk("clash_vchg", val_changed, 1);
        chk("clash_busy", busy, 0);
        chk("clash_done", done, 0);
`ifdef UPDATE_OVF_EN
        chk("clash_ovf_clr", ovf, 0);
`endif
        #1;
        chk("clash_ready_after", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("clash_accept", busy, 1);
        tick();
        chk("clash_set_val", val, 4);
        chk("clash_set_done", done, 1);

        // reset mid-WAIT with delay 7
        put_req(1'b0, 4'd1, 3'd7);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_val", val, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_vchg", val_changed, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", req_ready, 1);
        n_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || val_changed) n_pulses++;
        end
        chk("midrst_no_pulse", n_pulses, 0);
        chk("midrst_val_after", val, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
